// File: rtl/bc_rx_transfer.sv
// rtl/bc_rx_transfer.sv - bus-controller side of an MKIO BC->RT receive transfer
//
// Sends a command word and N buffered data words through the Manchester
// encoder, then waits (bounded by TIMEOUT) for the RT status word from the
// decoder and reports it with error flags.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request, ignored while busy
//   subaddr, word_count   transfer parameters, sampled on start (count 0 = 32)
//   tx_data/tx_cd/tx_ready  word, sync type and load strobe to the encoder
//   tx_busy               encoder transmitting
//   rx_done/rx_data/p_error decoded word strobe, word and parity error
//   addr_rd, rd_data      data buffer read port (1-clock read latency)
//   busy, done            transfer in progress, one-cycle completion pulse
//   stat_word, err_*      captured status word and error flags
module bc_rx_transfer #(
  parameter logic [4:0] RT_ADDR = 5'd1,
  parameter logic [9:0] TIMEOUT = 10'd200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  subaddr,
  input  logic [4:0]  word_count,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  output logic        tx_ready,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        p_error,
  output logic [4:0]  addr_rd,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] stat_word,
  output logic        err_timeout,
  output logic        err_addr,
  output logic        err_parity,
  output logic        err_msg
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_LOAD,
    S_CMD_GAP,
    S_CMD_WAIT,
    S_RD_ADDR,
    S_RD_DATA,
    S_DAT_LOAD,
    S_DAT_GAP,
    S_DAT_WAIT,
    S_RESP_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [5:0]  n_words;   // 1..32
  logic [9:0]  resp_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      n_words     <= 6'd0;
      resp_cnt    <= 10'd0;
      tx_data     <= 16'd0;
      tx_cd       <= 1'b0;
      tx_ready    <= 1'b0;
      addr_rd     <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stat_word   <= 16'd0;
      err_timeout <= 1'b0;
      err_addr    <= 1'b0;
      err_parity  <= 1'b0;
      err_msg     <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      tx_ready <= 1'b0;
      done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            n_words     <= (word_count == 5'd0) ? 6'd32 : {1'b0, word_count};
            tx_data     <= {RT_ADDR, 1'b0, subaddr, word_count};
            tx_cd       <= 1'b1;
            tx_ready    <= 1'b1;
            addr_rd     <= 5'd0;
            busy        <= 1'b1;
            stat_word   <= 16'd0;
            err_timeout <= 1'b0;
            err_addr    <= 1'b0;
            err_parity  <= 1'b0;
            err_msg     <= 1'b0;
            state       <= S_CMD_LOAD;
          end
        end

        S_CMD_LOAD: state <= S_CMD_GAP;

        // The encoder may not have raised tx_busy yet, so it is not looked at here.
        S_CMD_GAP:  state <= S_CMD_WAIT;

        S_CMD_WAIT: begin
          if (!tx_busy) state <= S_RD_ADDR;
        end

        // addr_rd is already stable; this cycle covers the buffer read latency.
        S_RD_ADDR:  state <= S_RD_DATA;

        S_RD_DATA: begin
          tx_data  <= rd_data;
          tx_cd    <= 1'b0;
          tx_ready <= 1'b1;
          state    <= S_DAT_LOAD;
        end

        S_DAT_LOAD: state <= S_DAT_GAP;

        S_DAT_GAP:  state <= S_DAT_WAIT;

        S_DAT_WAIT: begin
          if (!tx_busy) begin
            if ({1'b0, addr_rd} == n_words - 6'd1) begin
              resp_cnt <= 10'd0;
              state    <= S_RESP_WAIT;
            end else begin
              addr_rd <= addr_rd + 5'd1;
              state   <= S_RD_ADDR;
            end
          end
        end

        // A status word arriving on the timeout cycle still counts as a reply.
        S_RESP_WAIT: begin
          if (rx_done) begin
            stat_word  <= rx_data;
            err_parity <= p_error;
            err_addr   <= (rx_data[15:11] != RT_ADDR);
            err_msg    <= rx_data[10];
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else if (resp_cnt == TIMEOUT) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            resp_cnt <= resp_cnt + 10'd1;
          end
        end

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bc_rx_transfer.sv
// tb/tb_bc_rx_transfer.sv - self-checking bench for bc_rx_transfer
module tb_bc_rx_transfer;

  localparam logic [4:0] RT = 5'd1;
  localparam int         TO = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  subaddr = 5'd0;
  logic [4:0]  word_count = 5'd0;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy;
  logic        rx_done = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic        p_error = 1'b0;
  logic [4:0]  addr_rd;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] stat_word;
  logic        err_timeout;
  logic        err_addr;
  logic        err_parity;
  logic        err_msg;

  bc_rx_transfer #(.RT_ADDR(RT), .TIMEOUT(10'(TO))) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .subaddr(subaddr),
    .word_count(word_count), .tx_data(tx_data), .tx_cd(tx_cd),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .rx_done(rx_done),
    .rx_data(rx_data), .p_error(p_error), .addr_rd(addr_rd),
    .rd_data(rd_data), .busy(busy), .done(done), .stat_word(stat_word),
    .err_timeout(err_timeout), .err_addr(err_addr),
    .err_parity(err_parity), .err_msg(err_msg)
  );

  always #5 clk = ~clk;

  // Synchronous buffer with one clock of read latency.
  logic [15:0] mem [32];
  always @(posedge clk) rd_data <= mem[addr_rd];

  // Encoder model: every load keeps tx_busy high for enc_len clocks.
  // Each load is logged as {cd, addr_rd, data}.
  int          enc_len = 0;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_load_edge = 0;
  int          done_edge = 0;
  logic [21:0] log_q [$];

  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (!reset_n) begin
      busy_cnt <= 0;
    end else if (tx_ready) begin
      busy_cnt <= enc_len;
      log_q.push_back({tx_cd, addr_rd, tx_data});
      last_load_edge = cyc;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (done) begin
      done_cnt++;
      done_edge = cyc;
    end
    cyc = cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer followed by comparison against the expected word
  // stream and the status/error outcome derived from the reply.
  task automatic run_xfer(input logic [4:0] sa, input logic [4:0] wc, input int elen,
                          input bit do_reply, input int rdly, input logic [15:0] reply,
                          input bit perr, input bit disturb, input bit chk_timing);
    int          n;
    int          guard;
    int          wait_exit;
    logic [15:0] exp_cmd;
    logic [21:0] exp_w;
    logic [19:0] exp_res;
    n = (wc == 5'd0) ? 32 : int'(wc);
    exp_cmd = {RT, 1'b0, sa, wc};
    enc_len = elen;
    log_q.delete();
    done_cnt = 0;

    @(negedge clk);
    start = 1'b1; subaddr = sa; word_count = wc;
    @(negedge clk);
    start = 1'b0;

    if (disturb) begin
      guard = 0;
      while (log_q.size() < 1 && guard < 50) begin @(negedge clk); guard++; end
      repeat (3) @(negedge clk);
      rx_done = 1'b1; rx_data = 16'hFFFF; p_error = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; p_error = 1'b0;
      guard = 0;
      while (log_q.size() < 2 && guard < 200) begin @(negedge clk); guard++; end
      start = 1'b1; subaddr = ~sa; word_count = wc + 5'd1;
      @(negedge clk);
      start = 1'b0;
    end

    guard = 0;
    while (log_q.size() < n + 1 && guard < (n + 1) * (elen + 8) + 50) begin
      @(negedge clk); guard++;
    end
    check("word_total", log_q.size(), n + 1);
    guard = 0;
    while (tx_busy && guard < elen + 10) begin @(negedge clk); guard++; end

    if (do_reply) begin
      repeat (rdly) @(negedge clk);
      rx_done = 1'b1; rx_data = reply; p_error = perr;
      @(negedge clk);
      rx_done = 1'b0; p_error = 1'b0;
    end

    guard = 0;
    while (done_cnt == 0 && guard < TO + 100) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_after", busy, 1'b0);

    for (int i = 0; i <= n && i < log_q.size(); i++) begin
      if (i == 0) exp_w = {1'b1, 5'd0, exp_cmd};
      else        exp_w = {1'b0, 5'(i - 1), mem[i - 1]};
      check($sformatf("word%0d", i), log_q[i], exp_w);
    end

    if (do_reply)
      exp_res = {reply, 1'b0, reply[15:11] != RT, perr, reply[10]};
    else
      exp_res = {16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    check("status_errs", {stat_word, err_timeout, err_addr, err_parity, err_msg}, exp_res);

    // RESP_WAIT begins when the encoder first reports idle after the final
    // data gap; done follows TIMEOUT+1 clocks later, seen on the next edge.
    if (chk_timing && !do_reply) begin
      wait_exit = (elen + 1 > 2) ? elen + 1 : 2;
      check("timeout_edge", done_edge, last_load_edge + wait_exit + TO + 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("rst_tx", {tx_data, tx_cd, tx_ready, addr_rd}, 32'd0);
    check("rst_stat", {stat_word, busy, done, err_timeout, err_addr, err_parity, err_msg}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: 2 words, encoder busy 20, reply 0x0800 after 30 clocks.
    mem[0] = 16'hA5A5; mem[1] = 16'h5A5A;
    run_xfer(5'd3, 5'd2, 20, 1'b1, 30, 16'h0800, 1'b0, 1'b0, 1'b0);
    if (log_q.size() > 0) check("cmd_0862", log_q[0][15:0], 16'h0862);

    // 32-word transfer.
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    run_xfer(5'd7, 5'd0, 4, 1'b1, 10, 16'h0800, 1'b0, 1'b0, 1'b0);

    // No reply: timeout and its exact latency.
    run_xfer(5'd1, 5'd3, 6, 1'b0, 0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Wrong address plus message error, then a parity error.
    run_xfer(5'd2, 5'd1, 3, 1'b1, 5, 16'h1400, 1'b0, 1'b0, 1'b0);
    run_xfer(5'd2, 5'd1, 3, 1'b1, 5, 16'h0800, 1'b1, 1'b0, 1'b0);

    // Stray rx_done in CMD_WAIT and a second start mid-transfer.
    run_xfer(5'd9, 5'd4, 10, 1'b1, 8, 16'h0801, 1'b0, 1'b1, 1'b0);

    // Reset during DAT_WAIT.
    enc_len = 10;
    log_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; subaddr = 5'd5; word_count = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 100 && log_q.size() < 2; g++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", {tx_data, tx_cd, tx_ready, addr_rd}, 32'd0);
    check("abort_stat", {stat_word, busy, done, err_timeout, err_addr, err_parity, err_msg}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_xfer(5'd5, 5'd4, 2, 1'b1, 4, 16'h0810, 1'b0, 1'b0, 1'b0);

    // Randomised transfers.
    for (int k = 0; k < 8; k++) begin
      logic [4:0]  r_sa;
      logic [4:0]  r_wc;
      logic [15:0] r_rep;
      bit          r_do;
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      r_sa  = 5'($urandom);
      r_wc  = 5'($urandom_range(0, 31));
      r_rep = 16'($urandom);
      r_do  = ($urandom_range(0, 4) != 0);
      run_xfer(r_sa, r_wc, int'($urandom_range(0, 12)), r_do,
               int'($urandom_range(3, 80)), r_rep, 1'($urandom), 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bc_rx_transfer.md
Name: bc_rx_transfer

Overview:
- Bus-controller side of the MKIO BC→RT "receive" transfer; the opposite end of the remote-terminal receive device.
- On `start`, sends a command word, then N data words read from a dual-port buffer, through the Manchester encoder.
- Then waits, with a timeout, for the RT status word from the decoder.
- Reports the captured status and the error flags to the host logic.

Parameters:
- RT_ADDR, 5'd1, target remote-terminal address placed in the command word and checked in the status word.
- TIMEOUT, 10'd200, maximum clocks to wait in RESP_WAIT for the status word.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle transfer request; ignored while busy=1
- subaddr  in  5  subaddress, sampled on start
- word_count  in  5  data word count, sampled on start; 0 means 32
- tx_data  out  16  word to encoder
- tx_cd  out  1  1 = command sync, 0 = data sync
- tx_ready  out  1  one-cycle load strobe to encoder
- tx_busy  in  1  encoder transmitting
- rx_done  in  1  decoder word-valid strobe
- rx_data  in  16  decoded word
- p_error  in  1  parity error on current rx word, valid with rx_done
- addr_rd  out  5  buffer read address
- rd_data  in  16  buffer read data, 1-clock synchronous latency
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- stat_word  out  16  captured status word
- err_timeout  out  1  no status word within TIMEOUT
- err_addr  out  1  status address != RT_ADDR
- err_parity  out  1  status word parity error
- err_msg  out  1  status bit 10 (message error) set

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: tx_data, tx_cd, tx_ready, addr_rd, busy, done, stat_word, all err_*.
  - Counters are cleared.
- Latched on start in IDLE: subaddr, and n_words = (word_count==0) ? 32 : word_count (6-bit).
  - Also on start: busy=1, err_* cleared, addr_rd=0.
- Command word = {RT_ADDR, 1'b0 (T/R=receive), subaddr, word_count}; bits 15:11, 10, 9:5, 4:0.
- Encoder handshake for every word, as a 3-state sub-sequence:
  - LOAD: tx_data valid, tx_ready=1 for exactly one cycle.
  - GAP: one cycle, tx_busy ignored.
  - WAIT: hold until tx_busy=0.
  - tx_data is held stable from LOAD until leaving WAIT.
- State sequence:
  - IDLE: waits for start.
  - CMD_LOAD → CMD_GAP → CMD_WAIT: tx_cd=1, tx_data=command word.
  - RD_ADDR: addr_rd=word index; 1-cycle memory latency.
  - RD_DATA: rd_data is captured into tx_data.
  - DAT_LOAD → DAT_GAP → DAT_WAIT: tx_cd=0.
  - On leaving DAT_WAIT:
    - If index==n_words-1, go to RESP_WAIT.
    - Otherwise increment index and addr_rd, then go to RD_ADDR.
  - RESP_WAIT: 10-bit counter, cleared on entry, increments each cycle.
    - On rx_done: stat_word<=rx_data; err_parity<=p_error; err_addr<=(rx_data[15:11]!=RT_ADDR); err_msg<=rx_data[10]; go to DONE.
    - If counter==TIMEOUT without rx_done: err_timeout=1, stat_word unchanged (0); go to DONE.
    - rx_done and timeout in the same cycle: rx_done wins, err_timeout=0.
  - DONE: done=1 for one cycle, busy=0, go to IDLE. err_* and stat_word hold until the next start.
- Boundary conditions:
  - rx_done outside RESP_WAIT is ignored.
  - start while busy is ignored.
  - addr_rd covers 0..n_words-1 and never wraps within a transfer. With 32 words the last address is 31.
  - Words in a 32-word transfer: 1 command + 32 data.
  - reset_n low mid-transfer aborts immediately with no done pulse.
- Latency: start to command tx_ready = 1 clock (IDLE→CMD_LOAD). Each data word issues tx_ready 2 clocks after the previous WAIT exits.

Test Plan:
- start, subaddr=3, word_count=2, buffer[0]=16'hA5A5, buffer[1]=16'h5A5A, encoder busy 20 clk/word, RT replies 16'h0800 after 30 clk:
  - Transmitted words: 16'h0862 (tx_cd=1), then 16'hA5A5 and 16'h5A5A (tx_cd=0).
  - Exactly 3 tx_ready pulses.
  - done=1 once; stat_word=16'h0800; all err_*=0.
- word_count=0:
  - 33 tx_ready pulses; command low 5 bits = 0.
  - addr_rd sequence 0..31.
- No rx_done after the data words:
  - done exactly TIMEOUT+1 clocks after entering RESP_WAIT.
  - err_timeout=1, stat_word=0.
- Reply 16'h1400:
  - err_addr=1 (address 2 ≠ 1) and err_msg=1.
  - A separate reply with p_error=1 sets err_parity=1.
- Second start during data phase plus a stray rx_done during CMD_WAIT:
  - Both are ignored; the transfer completes normally.
- reset_n asserted mid DAT_WAIT:
  - All outputs are 0 asynchronously; no done pulse.
  - A following start sends the command word correctly.
